// File: rtl/alu_logic_pkg.sv
// Shared definitions for the iterative bitwise logic unit: operation
// encodings and the controller state type.
package alu_logic_pkg;

   localparam logic [2:0] LOGIC_AND  = 3'b000;
   localparam logic [2:0] LOGIC_OR   = 3'b001;
   localparam logic [2:0] LOGIC_XOR  = 3'b010;
   localparam logic [2:0] LOGIC_ANDN = 3'b011;
   localparam logic [2:0] LOGIC_NAND = 3'b100;
   localparam logic [2:0] LOGIC_NOR  = 3'b101;
   localparam logic [2:0] LOGIC_XNOR = 3'b110;
   localparam logic [2:0] LOGIC_NOTA = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-wide bitwise operator; one instance is time-shared
// across all slices of the operands.
module logic_slice
   import alu_logic_pkg::*;
#(
   parameter int SLICE = 16
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a_slice,
   input  logic [SLICE-1:0] b_slice,
   output logic [SLICE-1:0] y_slice
);

   always_comb begin
      y_slice = '0;
      case (op)
         LOGIC_AND:  y_slice = a_slice & b_slice;
         LOGIC_OR:   y_slice = a_slice | b_slice;
         LOGIC_XOR:  y_slice = a_slice ^ b_slice;
         LOGIC_ANDN: y_slice = a_slice & ~b_slice;
         LOGIC_NAND: y_slice = ~(a_slice & b_slice);
         LOGIC_NOR:  y_slice = ~(a_slice | b_slice);
         LOGIC_XNOR: y_slice = ~(a_slice ^ b_slice);
         LOGIC_NOTA: y_slice = ~a_slice;
         default:    y_slice = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_iter.sv
// Iterative bitwise logic unit: captures a request, evaluates one SLICE per
// cycle into a registered result, then holds result and flags until taken.
module logic_unit_iter
   import alu_logic_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output state_t           dbg_state
);

   localparam int NUM_SLICES = WIDTH / SLICE;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   generate
      if (WIDTH % SLICE != 0) begin : g_width_check
         $error("logic_unit_iter: WIDTH must be an integer multiple of SLICE");
      end
   endgenerate

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2:0]         r_op;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_zacc;
   logic [WIDTH-1:0]   r_result;
   logic               r_zf;
   logic               r_sf;

   logic [SLICE-1:0]   w_a_slice;
   logic [SLICE-1:0]   w_b_slice;
   logic [SLICE-1:0]   w_y_slice;
   logic               w_last;
   logic               w_zacc_next;

   assign w_a_slice   = r_a[r_cnt*SLICE +: SLICE];
   assign w_b_slice   = r_b[r_cnt*SLICE +: SLICE];
   assign w_last      = (r_cnt == CNT_W'(NUM_SLICES - 1));
   assign w_zacc_next = r_zacc & (w_y_slice == '0);

   logic_slice #(.SLICE(SLICE)) u_slice (
      .op      (r_op),
      .a_slice (w_a_slice),
      .b_slice (w_b_slice),
      .y_slice (w_y_slice)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Handshake: a transfer happens on any rising edge where valid and ready
   // are both high; ready/valid here are pure decodes of the state register.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= LOGIC_AND;
         r_cnt    <= '0;
         r_zacc   <= 1'b1;
         r_result <= '0;
         r_zf     <= 1'b0;
         r_sf     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_op   <= op;
                  r_cnt  <= '0;
                  r_zacc <= 1'b1;
               end
            end
            ST_RUN: begin
               r_result[r_cnt*SLICE +: SLICE] <= w_y_slice;
               r_zacc                         <= w_zacc_next;
               // Flags are committed only on the final slice so they never
               // reflect a partially computed result.
               if (w_last) begin
                  r_cnt <= '0;
                  r_zf  <= w_zacc_next;
                  r_sf  <= w_y_slice[SLICE-1];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign result    = r_result;
   assign zf        = r_zf;
   assign sf        = r_sf;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_logic_unit_iter.sv
// Directed bench for logic_unit_iter: table of operations on a 64/16 unit,
// handshake/reset corner sequences, and a single-slice 32/32 unit.
module tb_logic_unit_iter;
   import alu_logic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, zf, sf;
   logic [2:0]  op;
   logic [63:0] a, b, result;
   state_t      dbg_state;

   logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, zf_s, sf_s;
   logic [2:0]  op_s;
   logic [31:0] a_s, b_s, result_s;
   state_t      dbg_state_s;

   logic_unit_iter #(.WIDTH(64), .SLICE(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zf(zf), .sf(sf), .dbg_state(dbg_state)
   );

   logic_unit_iter #(.WIDTH(32), .SLICE(32)) u_dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .op(op_s), .a(a_s), .b(b_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
      .result(result_s), .zf(zf_s), .sf(sf_s), .dbg_state(dbg_state_s)
   );

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp_res;
      logic        exp_zf;
      logic        exp_sf;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Called at posedge+1 with the 64-bit unit idle; scrambles inputs after capture.
   task automatic run_op(input logic [2:0] t_op, input logic [63:0] t_a, input logic [63:0] t_b,
                         output logic [63:0] r, output logic z, output logic s, output int lat);
      op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; op = ~t_op; a = ~t_a; b = ~t_b;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result; z = zf; s = sf;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op_s(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                           output logic [31:0] r, output logic z, output logic s, output int lat);
      op_s = t_op; a_s = t_a; b_s = t_b; in_valid_s = 1'b1;
      @(posedge clk); #1;
      in_valid_s = 1'b0; a_s = ~t_a; b_s = ~t_b;
      lat = 0;
      while (!out_valid_s && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = result_s; z = zf_s; s = sf_s;
      out_ready_s = 1'b1;
      @(posedge clk); #1;
      out_ready_s = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r;
      logic [31:0] r32;
      logic        z, s, saw_valid;
      int          lat;

      vecs[0] = '{LOGIC_AND,  64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F00000F0F0000, 1'b0, 1'b0};
      vecs[1] = '{LOGIC_XOR,  64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 64'h0000000000000000, 1'b1, 1'b0};
      vecs[2] = '{LOGIC_NOR,  64'h0000000000000000, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1};
      vecs[3] = '{LOGIC_NOTA, 64'h7FFFFFFFFFFFFFFF, 64'h000000000000DEAD, 64'h8000000000000000, 1'b0, 1'b1};
      vecs[4] = '{LOGIC_OR,   64'h8000000000000000, 64'h0000000000000001, 64'h8000000000000001, 1'b0, 1'b1};
      vecs[5] = '{LOGIC_NAND, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b1, 1'b0};
      vecs[6] = '{LOGIC_XNOR, 64'h00000000FFFFFFFF, 64'h0000000000000000, 64'hFFFFFFFF00000000, 1'b0, 1'b1};
      vecs[7] = '{LOGIC_ANDN, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'h00F000F000F000F0, 1'b0, 1'b0};
      vecs[8] = '{LOGIC_AND,  64'h0000000000000001, 64'h0000000000000003, 64'h0000000000000001, 1'b0, 1'b0};
      vecs[9] = '{LOGIC_XOR,  64'h0001000000000000, 64'h0000000000000000, 64'h0001000000000000, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      in_valid_s = 1'b0; out_ready_s = 1'b0; op_s = '0; a_s = '0; b_s = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", result, 64'h0);
      check("reset_zf", 64'(zf), 64'h0);
      check("reset_sf", 64'(sf), 64'h0);
      check("reset_out_valid", 64'(out_valid), 64'h0);
      check("reset_in_ready", 64'(in_ready), 64'h1);
      check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
      check("reset_in_ready_s", 64'(in_ready_s), 64'h1);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, s, lat);
         check($sformatf("vec%0d_result", i), r, vecs[i].exp_res);
         check($sformatf("vec%0d_zf", i), 64'(z), 64'(vecs[i].exp_zf));
         check($sformatf("vec%0d_sf", i), 64'(s), 64'(vecs[i].exp_sf));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
         check($sformatf("vec%0d_idle_after", i), 64'(in_ready), 64'h1);
      end

      // Backpressure: hold DONE while a second request waits on in_valid.
      op = LOGIC_AND; a = 64'hFFFF0000FFFF0000; b = 64'h0F0F0F0F0F0F0F0F; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_busy_in_ready", 64'(in_ready), 64'h0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_latency", 64'(lat), 64'd4);
      op = LOGIC_XOR; a = 64'h123456789ABCDEF0; b = 64'h0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_result", i), result, 64'h0F0F00000F0F0000);
         check($sformatf("bp_hold%0d_zf_sf", i), {62'h0, zf, sf}, 64'h0);
         check($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'h0);
         check($sformatf("bp_hold%0d_out_valid", i), 64'(out_valid), 64'h1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_in_ready", 64'(in_ready), 64'h1);
      check("bp_release_out_valid", 64'(out_valid), 64'h0);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 64'h0; b = 64'hFFFF;
      check("bp_second_accepted", 64'(in_ready), 64'h0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp_second_latency", 64'(lat), 64'd4);
      check("bp_second_result", result, 64'h123456789ABCDEF0);
      check("bp_second_zf", 64'(zf), 64'h0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset during the second RUN cycle discards the operation.
      op = LOGIC_OR; a = 64'hFFFFFFFFFFFFFFFF; b = 64'h0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid_rst_result", result, 64'h0);
      check("mid_rst_in_ready", 64'(in_ready), 64'h1);
      check("mid_rst_out_valid", 64'(out_valid), 64'h0);
      saw_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      check("mid_rst_no_out_valid", 64'(saw_valid), 64'h0);
      run_op(LOGIC_ANDN, 64'hFF, 64'h0F, r, z, s, lat);
      check("post_rst_andn_result", r, 64'hF0);
      check("post_rst_andn_latency", 64'(lat), 64'd4);

      // Reset and in_valid together: nothing may be captured.
      rst = 1'b1; op = LOGIC_AND; a = '1; b = '1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid || !in_ready) saw_valid = 1'b1;
      end
      check("rst_with_valid_no_capture", 64'(saw_valid), 64'h0);
      check("rst_with_valid_result", result, 64'h0);

      // Single-slice configuration.
      run_op_s(LOGIC_OR, 32'h80000000, 32'h00000001, r32, z, s, lat);
      check("s32_or_result", 64'(r32), 64'h80000001);
      check("s32_or_sf", 64'(s), 64'h1);
      check("s32_or_zf", 64'(z), 64'h0);
      check("s32_or_latency", 64'(lat), 64'd1);
      run_op_s(LOGIC_AND, 32'h80000000, 32'h00000001, r32, z, s, lat);
      check("s32_and_result", 64'(r32), 64'h0);
      check("s32_and_zf", 64'(z), 64'h1);
      check("s32_and_sf", 64'(s), 64'h0);
      check("s32_idle_after", 64'(in_ready_s), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logic_unit_iter.md
# logic_unit_iter

Parametrised, iterative bitwise logic unit for the ALU of the sequential processor. It generalises the fixed 64-bit AND datapath to eight selectable bitwise operations over a configurable WIDTH. Operands are processed SLICE bits per cycle under a valid/ready handshake, which trades latency for area. The unit produces a registered result plus zero and sign flags for the condition-code logic.

## Interface
- WIDTH, 64, operand/result width in bits
- SLICE, 16, bits processed per cycle; WIDTH must be an integer multiple of SLICE
- NUM_SLICES, WIDTH/SLICE, derived localparam, not overridable
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request (high only in IDLE)
- op  input  3  operation select, encoding below
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result, zf and sf are valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zf  output  1  result == 0
- sf  output  1  result[WIDTH-1]

## Operation
- op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 ANDN (A & ~B)
  - 100 NAND
  - 101 NOR
  - 110 XNOR
  - 111 NOTA (~A); B is ignored.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture a, b and op into internal registers, clear slice counter cnt and zero accumulator, go to RUN.
- RUN:
  - Each cycle computes slice cnt of the captured operands and writes it to result[cnt*SLICE +: SLICE].
  - Each cycle ANDs "slice==0" into the zero accumulator, then cnt++.
  - When cnt==NUM_SLICES-1, go to DONE.
  - On entry to DONE, zf takes the final accumulator value and sf takes the MSB of the final slice.
- DONE:
  - out_valid=1.
  - result, zf and sf are held stable.
  - On out_ready, go to IDLE.
- Input ports are don't-care after capture; changes on a, b or op during RUN/DONE have no effect.
- in_valid outside IDLE is ignored; in_ready is low there.
- Bits of result not yet overwritten during RUN keep their previous values. Consumers must look only while out_valid is high.

## Timing
- Reset values:
  - state=IDLE, cnt=0
  - result=0, zf=0, sf=0
  - out_valid=0, in_ready=1 (decoded from state)
- Latency: request accepted at edge T, out_valid rises after edge T+NUM_SLICES (4 cycles for 64/16).
- Throughput with out_ready tied high: one op per NUM_SLICES+2 cycles.
- in_ready and out_valid are pure state decodes. There is no combinational path from in_valid or out_ready to any output.
- SLICE==WIDTH: single RUN cycle, latency 1.
- out_ready held low: remain in DONE indefinitely, outputs frozen.
- rst asserted in any state: immediate return to reset values, and any in-flight op is discarded with no out_valid.
- rst and in_valid high together: reset wins, nothing is captured.

## Structure
- Shared package alu_logic_pkg:
  - op encoding constants (LOGIC_AND … LOGIC_NOTA)
  - FSM state type/constants
- Sub-module logic_slice: combinational, SLICE-wide, inputs op, a_slice and b_slice, output y_slice. It is instantiated once and fed by a cnt-indexed mux of the captured operands.
- Top level holds the FSM, operand/op capture registers, cnt, result register and flag logic.
- Elaboration-time check: fail if WIDTH % SLICE != 0.

## Test plan
- AND (WIDTH=64, SLICE=16): a=0xFFFF0000FFFF0000, b=0x0F0F0F0F0F0F0F0F.
  - result=0x0F0F00000F0F0000, zf=0, sf=0.
  - out_valid exactly 4 cycles after acceptance.
- XOR: a=b=0x123456789ABCDEF0 -> result=0, zf=1, sf=0.
- NOR with a=b=0 -> result=0xFFFFFFFFFFFFFFFF, zf=0, sf=1.
- NOTA with a=0x7FFFFFFFFFFFFFFF and b=0xDEAD -> result=0x8000000000000000, sf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, and pulse in_valid with new operands.
  - result/flags stay stable and in_ready stays 0.
  - The second request is accepted only after out_ready and the return to IDLE.
- Reset mid-RUN: assert rst at the second RUN cycle.
  - out_valid never rises; result=0 and in_ready=1 immediately.
  - A following ANDN with a=0xFF, b=0x0F completes with result=0xF0.
- Config WIDTH=32, SLICE=32: OR of a=0x80000000 and b=0x1 gives result=0x80000001, sf=1, latency 1 cycle.
